// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and the length clamp for the serial pattern detector family
package seq_det_pkg;
   localparam int SEQ_MAX_W = 8;
   localparam int SEQ_LEN_W = $clog2(SEQ_MAX_W + 1);
   localparam logic [31:0] SEQ_DEF_PATTERN = 32'b0001_1011;
   localparam int SEQ_DEF_LEN = 5;
   function automatic int clamp_len(input int len, input int max_w);
      return (len < 2) ? 2 : ((len > max_w) ? max_w : len);
   endfunction
endpackage

// File: rtl/seq_match_cmp.sv
// seq_match_cmp: combinational masked compare of the low len bits of history against pattern
module seq_match_cmp #(
   parameter int MAX_W = 8,
   parameter int LEN_W = $clog2(MAX_W + 1)
) (
   input  logic [MAX_W-1:0] history_i,
   input  logic [MAX_W-1:0] pattern_i,
   input  logic [MAX_W-1:0] mask_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             hit_o
);
   logic [MAX_W-1:0] len_mask;
   // only bits below len take part; masked bits are don't-care
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_W; i++) len_mask[i] = LEN_W'(i) < len_i;
      hit_o = ~|((history_i ^ pattern_i) & ~mask_i & len_mask);
   end
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: programmable Moore serial pattern detector; SEQDET_MASK_EN adds a don't-care mask
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int                MAX_W       = SEQ_MAX_W,
   parameter logic [MAX_W-1:0]  DEF_PATTERN = MAX_W'(SEQ_DEF_PATTERN),
   parameter int                DEF_LEN     = SEQ_DEF_LEN,
   parameter int                CNT_W       = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic                         in_bit,
   input  logic                         overlap,
   input  logic                         cfg_load,
   input  logic [MAX_W-1:0]             cfg_pattern,
   input  logic [$clog2(MAX_W+1)-1:0]   cfg_len,
`ifdef SEQDET_MASK_EN
   input  logic [MAX_W-1:0]             cfg_mask,
`endif
   input  logic                         cnt_clr,
   output logic                         detect,
   output logic [CNT_W-1:0]             match_cnt,
   output logic [$clog2(MAX_W+1)-1:0]   fill
);
   localparam int LEN_W = $clog2(MAX_W + 1);
   logic [MAX_W-1:0] pattern_q, pattern_d, history_q, history_d, hist_shift, mask_w;
   logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d, fill_inc;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             detect_q, detect_d, accept, hit, cmp_hit;
`ifdef SEQDET_MASK_EN
   logic [MAX_W-1:0] mask_q;
   // mask is latched with the rest of the configuration
   always_ff @(posedge clk) begin
      if (rst) mask_q <= '0;
      else if (cfg_load) mask_q <= cfg_mask;
   end
   assign mask_w = mask_q;
`else
   assign mask_w = '0;
`endif
   assign hist_shift = {history_q[MAX_W-2:0], in_bit};
   seq_match_cmp #(.MAX_W(MAX_W), .LEN_W(LEN_W)) u_cmp (
      .history_i (hist_shift),
      .pattern_i (pattern_q),
      .mask_i    (mask_w),
      .len_i     (len_q),
      .hit_o     (cmp_hit)
   );
   // next state: shift on accepted bits, fill saturates at len, config load restarts the window
   always_comb begin
      accept    = in_valid & ~cfg_load;
      fill_inc  = (fill_q < len_q) ? fill_q + 1'b1 : fill_q;
      hit       = accept & (fill_inc >= len_q) & cmp_hit;
      history_d = accept ? hist_shift : history_q;
      fill_d    = cfg_load ? '0 : !accept ? fill_q : (hit && !overlap) ? '0 : fill_inc;
      detect_d  = hit;
      cnt_d     = cnt_clr ? CNT_W'(hit) : (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
      pattern_d = cfg_load ? cfg_pattern : pattern_q;
      len_d     = cfg_load ? LEN_W'(clamp_len(int'(cfg_len), MAX_W)) : len_q;
   end
   // state registers with synchronous reset to the default configuration
   always_ff @(posedge clk) begin
      if (rst) begin
         pattern_q <= DEF_PATTERN;
         len_q     <= LEN_W'(DEF_LEN);
         history_q <= '0;
         fill_q    <= '0;
         detect_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         pattern_q <= pattern_d;
         len_q     <= len_d;
         history_q <= history_d;
         fill_q    <= fill_d;
         detect_q  <= detect_d;
         cnt_q     <= cnt_d;
      end
   end
   assign detect    = detect_q;
   assign match_cnt = cnt_q;
   assign fill      = fill_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed self-checking bench for seq_detector_param (SEQDET_MASK_EN optional)
module tb_seq_detector_param;
   logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_bit = 1'b0, overlap = 1'b1;
   logic       cfg_load = 1'b0, cnt_clr = 1'b0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;
   logic [7:0] cfg_mask = '0;
   logic       detect;
   logic [7:0] match_cnt;
   logic [3:0] fill;
   int         total = 0, bad = 0;
   seq_detector_param #(.MAX_W(8), .DEF_PATTERN(8'b0001_1011), .DEF_LEN(5), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .overlap(overlap),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
`ifdef SEQDET_MASK_EN
      .cfg_mask(cfg_mask),
`endif
      .cnt_clr(cnt_clr), .detect(detect), .match_cnt(match_cnt), .fill(fill)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic step(input logic v, input logic b);
      in_valid = v;
      in_bit   = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cfg_load = 1'b0;
      cnt_clr  = 1'b0;
      rst      = 1'b0;
   endtask
   task automatic feed(input string tag, input logic [31:0] bits, input int n, input logic [31:0] dexp);
      for (int k = 0; k < n; k++) begin
         step(1'b1, bits[n-1-k]);
         check($sformatf("%s_det[%0d]", tag, k), detect, dexp[n-1-k]);
      end
   endtask
   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 1'b0);
   endtask
   initial begin
      do_reset();
      check("rst_det", detect, 0);
      check("rst_cnt", match_cnt, 0);
      check("rst_fill", fill, 0);
      overlap = 1'b1;
      feed("ovl", 32'b1101_1011, 8, 32'b0000_1001);
      check("ovl_cnt", match_cnt, 2);
      check("ovl_fill", fill, 5);
      do_reset();
      overlap = 1'b0;
      feed("novl", 32'b1101_1011, 8, 32'b0000_1000);
      check("novl_cnt", match_cnt, 1);
      check("novl_fill", fill, 3);
      do_reset();
      overlap = 1'b1;
      feed("gap_a", 32'b110, 3, 32'b000);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1);
         check($sformatf("gap_det[%0d]", k), detect, 0);
         check($sformatf("gap_fill[%0d]", k), fill, 3);
      end
      feed("gap_b", 32'b11, 2, 32'b01);
      check("gap_cnt", match_cnt, 1);
      do_reset();
      feed("pre", 32'b101, 3, 32'b000);
      check("pre_fill", fill, 3);
      cfg_load    = 1'b1;
      cfg_pattern = 8'b1010_0101;
      cfg_len     = 4'd8;
      step(1'b1, 1'b1);
      check("ld_fill", fill, 0);
      check("ld_det", detect, 0);
      feed("a5", 32'hA5, 8, 32'h01);
      check("a5_cnt", match_cnt, 1);
      check("a5_fill", fill, 8);
      cfg_load    = 1'b1;
      cfg_pattern = 8'b1010_0111;
      cfg_len     = 4'd0;
      step(1'b0, 1'b0);
      check("len0_fill", fill, 0);
      check("len0_cnt", match_cnt, 1);
      feed("len2", 32'b11, 2, 32'b01);
      check("len2_fill", fill, 2);
      cnt_clr = 1'b1;
      step(1'b0, 1'b0);
      check("clr_cnt", match_cnt, 0);
      for (int k = 0; k < 256; k++) step(1'b1, 1'b1);
      check("sat_cnt", match_cnt, 255);
      step(1'b1, 1'b1);
      check("sat_det", detect, 1);
      check("sat_hold", match_cnt, 255);
      cnt_clr = 1'b1;
      step(1'b1, 1'b1);
      check("clrhit_cnt", match_cnt, 1);
      cnt_clr = 1'b1;
      step(1'b0, 1'b0);
      check("clronly_cnt", match_cnt, 0);
      do_reset();
      feed("rstm", 32'b1101, 4, 32'b0000);
      rst = 1'b1;
      step(1'b1, 1'b1);
      check("rstm_det", detect, 0);
      check("rstm_fill", fill, 0);
      check("rstm_cnt", match_cnt, 0);
      feed("post", 32'b11011, 5, 32'b00001);
`ifdef SEQDET_MASK_EN
      cfg_load    = 1'b1;
      cfg_pattern = 8'b0001_1011;
      cfg_len     = 4'd5;
      cfg_mask    = 8'b0000_0100;
      step(1'b0, 1'b0);
      feed("mask", 32'b11111, 5, 32'b00001);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
